// File: rtl/membus_pkg.sv
// Shared types and constants for the memory-bus controller.
package membus_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } state_e;

  // io_mode[1:0] access sizes; 3 is treated as a word.
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Address of MMIO register 0; register i lives 4*i bytes below.
  localparam logic [31:0] IO_TOP = 32'hFFFF_FFFC;

  // Register index for a word address (address bits [31:2]).
  function automatic logic [31:0] io_index(input logic [29:0] word_addr);
    return {2'b00, IO_TOP[31:2] - word_addr};
  endfunction

endpackage

// File: rtl/membus_lane.sv
// Byte-lane steering: store enables/replication, misalign detect, load align/extend.
module membus_lane
  import membus_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  io_mode_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misaligned_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;
  logic        sext;

  // Decode size into lane enables, replicated store data and extended load data.
  always_comb begin
    shifted      = rword_i >> {addr_lo_i, 3'b000};
    sext         = ~io_mode_i[2];
    be_o         = 4'b1111;
    wdata_o      = wdata_i;
    misaligned_o = 1'b0;
    rdata_o      = shifted;
    unique case (io_mode_i[1:0])
      SZ_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{sext & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        be_o         = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o      = {2{wdata_i[15:0]}};
        misaligned_o = addr_lo_i[0];
        rdata_o      = {{16{sext & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        misaligned_o = (addr_lo_i != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/membus_ctrl.sv
// Memory-bus controller: toggle-ack core port to byte-enabled RAM plus MMIO registers.
module membus_ctrl
  import membus_pkg::*;
#(
  parameter int unsigned RAM_ADDR_W = 14,
  parameter int unsigned NUM_IO     = 1,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    core_addr_valid,
  input  logic [31:0]             core_addr,
  input  logic                    core_data_valid,
  input  logic [31:0]             core_wdata,
  input  logic [2:0]              core_io_mode,
  input  logic                    core_ack,
  output logic                    core_addr_ack,
  output logic                    core_ready,
  output logic                    core_write_done,
  output logic [31:0]             core_rdata,
  output logic                    core_error,
  output logic                    mem_enable,
  output logic                    mem_write,
  output logic [3:0]              mem_byte_enable,
  output logic [RAM_ADDR_W-1:0]   mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic [31:0]             mem_rdata,
  input  logic                    mem_busy,
  output logic [32*NUM_IO-1:0]    io_regs
);

  state_e                     state_q, state_d;
  logic                       ack_q, ack_d, ready_q, ready_d, wdone_q, wdone_d;
  logic                       error_q, error_d, men_q, men_d, mwrite_q, mwrite_d;
  logic                       store_q, store_d;
  logic [31:0]                rdata_q, rdata_d, mwdata_q, mwdata_d, wd_q, wd_d;
  logic [3:0]                 be_q, be_d;
  logic [RAM_ADDR_W-1:0]      maddr_q, maddr_d;
  logic [1:0]                 addr_lo_q, addr_lo_d;
  logic [2:0]                 mode_q, mode_d;
  logic [NUM_IO-1:0][31:0]    io_q, io_d;

  logic [31:0] io_idx, io_word, lane_rword, lane_wdata, lane_rdata;
  logic [3:0]  lane_be;
  logic [1:0]  lane_addr_lo;
  logic [2:0]  lane_mode;
  logic        lane_misaligned, ram_hit, io_hit, is_idle;

  assign is_idle = (state_q == StIdle);
  assign io_idx  = io_index(core_addr[31:2]);
  assign ram_hit = (core_addr[31:RAM_ADDR_W] == '0);
  assign io_hit  = (io_idx < 32'(NUM_IO));

  // The lane unit serves the live request in IDLE and the latched one on RAM return.
  assign lane_addr_lo = is_idle ? core_addr[1:0] : addr_lo_q;
  assign lane_mode    = is_idle ? core_io_mode : mode_q;
  assign lane_rword   = is_idle ? io_word : mem_rdata;

  membus_lane u_lane (
    .addr_lo_i    (lane_addr_lo),
    .io_mode_i    (lane_mode),
    .wdata_i      (core_wdata),
    .rword_i      (lane_rword),
    .be_o         (lane_be),
    .wdata_o      (lane_wdata),
    .misaligned_o (lane_misaligned),
    .rdata_o      (lane_rdata)
  );

  // Select the addressed MMIO register for readback.
  always_comb begin
    io_word = '0;
    for (int i = 0; i < NUM_IO; i++) begin
      if (io_idx == 32'(i)) io_word = io_q[i];
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    ack_d     = ack_q;
    ready_d   = ready_q;
    wdone_d   = wdone_q;
    error_d   = error_q;
    men_d     = men_q;
    mwrite_d  = mwrite_q;
    store_d   = store_q;
    rdata_d   = rdata_q;
    mwdata_d  = mwdata_q;
    wd_d      = wd_q;
    be_d      = be_q;
    maddr_d   = maddr_q;
    addr_lo_d = addr_lo_q;
    mode_d    = mode_q;
    io_d      = io_q;
    unique case (state_q)
      StIdle: begin
        if (core_addr_valid && (core_ack != ack_q)) begin
          ack_d     = core_ack;
          ready_d   = 1'b0;
          error_d   = 1'b0;
          wdone_d   = 1'b0;
          store_d   = core_data_valid;
          addr_lo_d = core_addr[1:0];
          mode_d    = core_io_mode;
          if (lane_misaligned || !(ram_hit || io_hit)) begin
            error_d = 1'b1;
            rdata_d = '0;
            state_d = StDone;
          end else if (ram_hit) begin
            maddr_d  = core_addr[RAM_ADDR_W-1:0];
            be_d     = lane_be;
            mwdata_d = lane_wdata;
            mwrite_d = core_data_valid;
            men_d    = 1'b1;
            state_d  = StIssue;
          end else begin
            if (core_data_valid) begin
              for (int i = 0; i < NUM_IO; i++) begin
                if (io_idx == 32'(i)) begin
                  for (int b = 0; b < 4; b++) begin
                    if (lane_be[b]) io_d[i][8*b+:8] = lane_wdata[8*b+:8];
                  end
                end
              end
            end else begin
              rdata_d = lane_rdata;
            end
            state_d = StDone;
          end
        end
      end
      StIssue: begin
        men_d    = 1'b0;
        be_d     = '0;
        mwrite_d = 1'b0;
        wd_d     = '0;
        state_d  = StWait;
      end
      StWait: begin
        if (!mem_busy) begin
          if (!store_q) rdata_d = lane_rdata;
          ready_d = 1'b1;
          wdone_d = store_q;
          state_d = StIdle;
        end else begin
          wd_d = wd_q + 32'd1;
          if ((TIMEOUT != 0) && (wd_q + 32'd1 == TIMEOUT)) begin
            error_d = 1'b1;
            ready_d = 1'b1;
            wdone_d = store_q;
            state_d = StIdle;
          end
        end
      end
      StDone: begin
        ready_d = 1'b1;
        wdone_d = store_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      ack_q     <= 1'b0;
      ready_q   <= 1'b0;
      wdone_q   <= 1'b1;
      error_q   <= 1'b0;
      men_q     <= 1'b0;
      mwrite_q  <= 1'b0;
      store_q   <= 1'b0;
      rdata_q   <= '0;
      mwdata_q  <= '0;
      wd_q      <= '0;
      be_q      <= '0;
      maddr_q   <= '0;
      addr_lo_q <= '0;
      mode_q    <= '0;
      io_q      <= '0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      ready_q   <= ready_d;
      wdone_q   <= wdone_d;
      error_q   <= error_d;
      men_q     <= men_d;
      mwrite_q  <= mwrite_d;
      store_q   <= store_d;
      rdata_q   <= rdata_d;
      mwdata_q  <= mwdata_d;
      wd_q      <= wd_d;
      be_q      <= be_d;
      maddr_q   <= maddr_d;
      addr_lo_q <= addr_lo_d;
      mode_q    <= mode_d;
      io_q      <= io_d;
    end
  end

  assign core_addr_ack   = ack_q;
  assign core_ready      = ready_q;
  assign core_write_done = wdone_q;
  assign core_rdata      = rdata_q;
  assign core_error      = error_q;
  assign mem_enable      = men_q;
  assign mem_write       = mwrite_q;
  assign mem_byte_enable = be_q;
  assign mem_addr        = maddr_q;
  assign mem_wdata       = mwdata_q;
  assign io_regs         = io_q;

endmodule

// File: tb/tb_membus_ctrl.sv
// Directed self-checking bench for membus_ctrl (RAM_ADDR_W=14, NUM_IO=2, TIMEOUT=4).
module tb_membus_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        core_addr_valid = 1'b0;
  logic [31:0] core_addr = '0;
  logic        core_data_valid = 1'b0;
  logic [31:0] core_wdata = '0;
  logic [2:0]  core_io_mode = '0;
  logic        core_ack = 1'b0;
  logic        core_addr_ack, core_ready, core_write_done, core_error;
  logic [31:0] core_rdata;
  logic        mem_enable, mem_write;
  logic [3:0]  mem_byte_enable;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_busy = 1'b0;
  logic [63:0] io_regs;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram [0:4095];

  membus_ctrl #(
    .RAM_ADDR_W (14),
    .NUM_IO     (2),
    .TIMEOUT    (4)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .core_addr_valid (core_addr_valid),
    .core_addr       (core_addr),
    .core_data_valid (core_data_valid),
    .core_wdata      (core_wdata),
    .core_io_mode    (core_io_mode),
    .core_ack        (core_ack),
    .core_addr_ack   (core_addr_ack),
    .core_ready      (core_ready),
    .core_write_done (core_write_done),
    .core_rdata      (core_rdata),
    .core_error      (core_error),
    .mem_enable      (mem_enable),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_busy        (mem_busy),
    .io_regs         (io_regs)
  );

  always #5 clk = ~clk;

  // Simple synchronous byte-enabled RAM.
  always @(posedge clk) begin
    if (mem_enable) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_byte_enable[b]) ram[mem_addr[13:2]][8*b+:8] <= mem_wdata[8*b+:8];
        end
      end else begin
        mem_rdata <= ram[mem_addr[13:2]];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Issue one request; report edges-after-accept until ready, enable pulses and lanes seen.
  task automatic access(input logic [31:0] addr, input logic [31:0] wd, input logic st,
                        input logic [2:0] mode, output int lat, output int en_cnt,
                        output logic [3:0] be_seen);
    @(negedge clk);
    core_addr_valid = 1'b1;
    core_addr       = addr;
    core_wdata      = wd;
    core_data_valid = st;
    core_io_mode    = mode;
    core_ack        = ~core_ack;
    @(posedge clk);
    lat     = -1;
    en_cnt  = 0;
    be_seen = '0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (mem_enable) begin
        en_cnt++;
        be_seen = mem_byte_enable;
      end
      if (core_ready) begin
        lat = c;
        break;
      end
    end
  endtask

  int         lat, en, n;
  logic [3:0] be;
  logic       first_ack;

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", core_ready, 0);
    check("rst_wdone", core_write_done, 1);
    check("rst_ack", core_addr_ack, 0);
    check("rst_rdata", core_rdata, 0);
    check("rst_error", core_error, 0);
    check("rst_men", {mem_enable, mem_write, mem_byte_enable}, 0);
    check("rst_io", io_regs, 0);
    reset_n = 1'b1;

    // RAM word store then load.
    access(32'h100, 32'hDEAD_BEEF, 1'b1, 3'd2, lat, en, be);
    check("sw_lat", lat, 2);
    check("sw_en", en, 1);
    check("sw_be", be, 4'b1111);
    check("sw_err", core_error, 0);
    check("sw_wdone", core_write_done, 1);
    access(32'h100, 32'h0, 1'b0, 3'd2, lat, en, be);
    check("lw_lat", lat, 2);
    check("lw_data", core_rdata, 32'hDEAD_BEEF);
    check("lw_err", core_error, 0);
    check("lw_wdone", core_write_done, 0);

    // Byte store, signed/unsigned byte and half loads.
    access(32'h103, 32'h0000_0080, 1'b1, 3'd0, lat, en, be);
    check("sb_be", be, 4'b1000);
    access(32'h103, 32'h0, 1'b0, 3'd0, lat, en, be);
    check("lb_data", core_rdata, 32'hFFFF_FF80);
    access(32'h103, 32'h0, 1'b0, 3'd4, lat, en, be);
    check("lbu_data", core_rdata, 32'h0000_0080);
    access(32'h102, 32'h0, 1'b0, 3'd1, lat, en, be);
    check("lh_data", core_rdata, 32'hFFFF_80AD);
    access(32'h100, 32'h0, 1'b0, 3'd5, lat, en, be);
    check("lhu_data", core_rdata, 32'h0000_BEEF);

    // MMIO store, half store into register 1, readback.
    access(32'hFFFF_FFFC, 32'h1234_5678, 1'b1, 3'd2, lat, en, be);
    check("io_sw_lat", lat, 1);
    check("io_sw_en", en, 0);
    check("io_sw_reg", io_regs[31:0], 32'h1234_5678);
    access(32'hFFFF_FFFA, 32'h0000_ABCD, 1'b1, 3'd1, lat, en, be);
    check("io_sh_reg", io_regs, 64'hABCD_0000_1234_5678);
    access(32'hFFFF_FFFC, 32'h0, 1'b0, 3'd2, lat, en, be);
    check("io_lw_lat", lat, 1);
    check("io_lw_data", core_rdata, 32'h1234_5678);
    access(32'hFFFF_FFFA, 32'h0, 1'b0, 3'd5, lat, en, be);
    check("io_lhu_data", core_rdata, 32'h0000_ABCD);

    // Misaligned load and unmapped store.
    access(32'h102, 32'h0, 1'b0, 3'd2, lat, en, be);
    check("mis_lat", lat, 1);
    check("mis_err", core_error, 1);
    check("mis_en", en, 0);
    check("mis_rdata", core_rdata, 0);
    access(32'h0001_0000, 32'h5555_5555, 1'b1, 3'd2, lat, en, be);
    check("unm_err", core_error, 1);
    check("unm_en", en, 0);
    check("unm_wdone", core_write_done, 1);
    check("unm_io", io_regs, 64'hABCD_0000_1234_5678);

    // Watchdog: four busy WAIT cycles force an error completion.
    mem_busy = 1'b1;
    access(32'h100, 32'h0, 1'b0, 3'd2, lat, en, be);
    check("to_lat", lat, 5);
    check("to_err", core_error, 1);
    check("to_ready", core_ready, 1);
    mem_busy = 1'b0;
    access(32'h100, 32'h0, 1'b0, 3'd2, lat, en, be);
    check("after_to_lat", lat, 2);
    check("after_to_data", core_rdata, 32'h80AD_BEEF);
    check("after_to_err", core_error, 0);

    // A toggle during WAIT is held off, then accepted exactly once.
    mem_busy = 1'b1;
    @(negedge clk);
    core_addr = 32'h100; core_data_valid = 1'b0; core_io_mode = 3'd2;
    core_ack  = ~core_ack;
    first_ack = core_ack;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    core_ack = ~core_ack;
    @(negedge clk);
    check("hold_ack", core_addr_ack, first_ack);
    mem_busy = 1'b0;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (mem_enable) n++;
    end
    check("one_accept", n, 1);
    check("second_ack", core_addr_ack, core_ack);
    check("second_ready", core_ready, 1);

    // Asynchronous reset while the RAM strobe is high.
    mem_busy = 1'b1;
    @(negedge clk);
    core_ack = ~core_ack;
    @(posedge clk);
    @(negedge clk);
    check("pre_rst_en", mem_enable, 1);
    #2;
    reset_n         = 1'b0;
    core_addr_valid = 1'b0;
    core_ack        = 1'b0;
    #1;
    check("arst_men", {mem_enable, mem_write, mem_byte_enable}, 0);
    check("arst_core", {core_ready, core_write_done, core_addr_ack, core_error}, 4'b0100);
    check("arst_rdata", core_rdata, 0);
    check("arst_io", io_regs, 0);
    @(negedge clk);
    reset_n  = 1'b1;
    mem_busy = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
